// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants and FSM state type for the ALU arbiter.
//   ALU_ADD..ALU_XOR : legal ALU opcodes; anything above ALU_OP_MAX is illegal.
//   alu_arb_state_t  : IDLE (arbitrate), EXEC (drive ALU), RESP (hold response).
package alu_pkg;
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_OP_MAX = 4'd4;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} alu_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority; search proceeds upward with wrap
//   grant : one-hot winner (all-zero when no request)
//   id    : encoded winner index (0 when no request)
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    id
);
   // One extra bit so ptr + offset never overflows before the wrap subtract.
   logic [ID_W:0] idx;
   logic          found;

   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
         if (!found && req[idx[ID_W-1:0]]) begin
            grant[idx[ID_W-1:0]] = 1'b1;
            id    = idx[ID_W-1:0];
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ requesters using
// round-robin arbitration, sequencing IDLE -> EXEC -> RESP per operation.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready            : per-requester handshake (req_ready one-hot)
//   req_opcode/req_a/req_b         : packed per-requester opcode and operands
//   resp_valid/resp_ready          : response handshake
//   resp_id/resp_data/resp_err     : response payload
//   alu_opcode/alu_exec/alu_a/alu_b: ALU drive; alu_result: ALU output
// Optional macro ALU_ARB_OPCHECK_EN: illegal opcodes bypass EXEC and return
// resp_err = 1 with resp_data = 0; otherwise resp_err is tied to 0.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [4*NUM_REQ-1:0]     req_opcode,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [WIDTH-1:0]         resp_data,
   output logic                     resp_err,
   output logic [3:0]               alu_opcode,
   output logic                     alu_exec,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   input  logic [WIDTH-1:0]         alu_result
);
   alu_arb_state_t     state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    id_q;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   data_q;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    win_id;
   logic               accept;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .id    (win_id)
   );

   // rst_n gating keeps req_ready low while reset is held, even though the
   // state register already reads IDLE.
   assign req_ready  = (state == IDLE && rst_n) ? grant : '0;
   assign accept     = |(req_valid & req_ready);
   assign alu_exec   = (state == EXEC);
   assign resp_valid = (state == RESP);
   assign alu_opcode = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign resp_id    = id_q;
   assign resp_data  = data_q;

`ifdef ALU_ARB_OPCHECK_EN
   logic err_q;
   logic illegal;
   assign illegal  = req_opcode[win_id*4 +: 4] > ALU_OP_MAX;
   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         id_q   <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         data_q <= '0;
`ifdef ALU_ARB_OPCHECK_EN
         err_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q   <= req_opcode[win_id*4 +: 4];
               a_q    <= req_a[win_id*WIDTH +: WIDTH];
               b_q    <= req_b[win_id*WIDTH +: WIDTH];
               id_q   <= win_id;
               rr_ptr <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
               err_q  <= illegal;
               data_q <= '0;
               state  <= illegal ? RESP : EXEC;
`else
               state  <= EXEC;
`endif
            end
            EXEC: begin
               data_q <= alu_result;
               state  <= RESP;
            end
            RESP: if (resp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
